// File: rtl/jtag_pkg.sv
// Shared encodings and pin-mapping helper for the JTAG shift engine.
// Op codes match the VPI driver's command numbering.
package jtag_pkg;

  typedef enum logic [1:0] {
    JTAG_OP_RESET         = 2'd0,
    JTAG_OP_TMS_SEQ       = 2'd1,
    JTAG_OP_SCAN          = 2'd2,
    JTAG_OP_SCAN_FLIP_TMS = 2'd3
  } jtag_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOW,
    ST_HIGH,
    ST_STORE
  } jtag_state_e;

  typedef struct packed {
    logic tms;
    logic tdi;
  } jtag_pins_t;

  // TAP reset: five TMS=1 pulses then one TMS=0, fed through the TMS path.
  localparam logic [7:0]  RESET_TMS_PATTERN = 8'h1F;
  localparam int unsigned RESET_NBITS       = 6;

  function automatic logic op_has_tdo(input jtag_op_e op);
    return (op == JTAG_OP_SCAN) || (op == JTAG_OP_SCAN_FLIP_TMS);
  endfunction

  function automatic jtag_pins_t pin_map(input jtag_op_e op, input logic data_bit,
                                         input logic last_bit);
    jtag_pins_t p;
    p.tms = 1'b0;
    p.tdi = 1'b0;
    case (op)
      JTAG_OP_RESET, JTAG_OP_TMS_SEQ: p.tms = data_bit;
      JTAG_OP_SCAN:                   p.tdi = data_bit;
      default: begin
        p.tdi = data_bit;
        p.tms = last_bit;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: toggles tck every TCK_DIV cycles while run is high and
// holds the phase counter at zero otherwise, so stalls only lengthen LOW.
module jtag_tck_gen #(
  parameter int unsigned TCK_DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tck,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned    DIV_W    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tck_q, tck_d;
  logic             tick;

  always_comb begin
    tick   = run && (div_q == DIV_LAST);
    rise_c = tick && !tck_q;
    fall_c = tick && tck_q;
    div_d  = div_q;
    tck_d  = tck_q;
    if (!run) begin
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
      tck_d = !tck_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tck_q <= tck_d;
    end
  end

  assign tck = tck_q;

endmodule

// File: rtl/jtag_shift_engine.sv
// JTAG master: runs RESET / TMS_SEQ / SCAN / SCAN_FLIP_TMS commands,
// streaming TMS/TDI bytes in and captured TDO bytes out over valid/ready.
module jtag_shift_engine
  import jtag_pkg::*;
#(
  parameter int unsigned TCK_DIV = 5,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_nbits,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             tck,
  output logic             tms,
  output logic             tdi,
  input  logic             tdo
);

  jtag_state_e      state_q, state_d;
  jtag_op_e         op_q, op_d;
  logic [LEN_W-1:0] nbits_q, nbits_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       wbuf_q, wbuf_d;
  logic [7:0]       rbuf_q, rbuf_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  jtag_pins_t       pins_q, pins_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             wr_ready_q, wr_ready_d;
  logic             busy_q, busy_d;
  logic             load_pins, clear_pins, bit_last;
  logic             rise_c, fall_c, tck_run;

  assign tck_run = (state_q == ST_LOW) || (state_q == ST_HIGH);

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (tck_run),
    .tck    (tck),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    nbits_d    = nbits_q;
    cnt_d      = cnt_q;
    wbuf_d     = wbuf_q;
    rbuf_d     = rbuf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q && !rd_ready;
    pins_d     = pins_q;
    load_pins  = 1'b0;
    clear_pins = 1'b0;
    bit_last   = (cnt_q + LEN_W'(1)) == nbits_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = jtag_op_e'(cmd_op);
          cnt_d   = '0;
          rbuf_d  = '0;
          nbits_d = (op_d == JTAG_OP_RESET) ? LEN_W'(RESET_NBITS) : cmd_nbits;
          // Zero-length shifts retire on acceptance.
          if ((op_d == JTAG_OP_RESET) || (cmd_nbits != '0)) state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (op_q == JTAG_OP_RESET) begin
          wbuf_d    = RESET_TMS_PATTERN;
          load_pins = 1'b1;
          state_d   = ST_LOW;
        end else if (wr_valid && wr_ready_q) begin
          wbuf_d    = wr_data;
          load_pins = 1'b1;
          state_d   = ST_LOW;
        end
      end
      ST_LOW: begin
        if (rise_c) begin
          rbuf_d[cnt_q[2:0]] = tdo;
          state_d            = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall_c) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (bit_last) clear_pins = 1'b1;
          if (bit_last || (cnt_q[2:0] == 3'd7)) begin
            if (op_has_tdo(op_q)) state_d = ST_STORE;
            else                  state_d = bit_last ? ST_IDLE : ST_FETCH;
          end else begin
            load_pins = 1'b1;
            state_d   = ST_LOW;
          end
        end
      end
      ST_STORE: begin
        if (!rd_valid_q || rd_ready) begin
          rd_data_d  = rbuf_q;
          rd_valid_d = 1'b1;
          rbuf_d     = '0;
          state_d    = (cnt_q == nbits_q) ? ST_IDLE : ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear_pins) begin
      pins_d = '0;
    end else if (load_pins) begin
      pins_d = pin_map(op_q, wbuf_d[cnt_d[2:0]], cnt_d == (nbits_q - LEN_W'(1)));
    end

    cmd_ready_d = (state_d == ST_IDLE);
    wr_ready_d  = (state_d == ST_FETCH) && (op_d != JTAG_OP_RESET);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= JTAG_OP_RESET;
      nbits_q     <= '0;
      cnt_q       <= '0;
      wbuf_q      <= '0;
      rbuf_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      pins_q      <= '0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      nbits_q     <= nbits_d;
      cnt_q       <= cnt_d;
      wbuf_q      <= wbuf_d;
      rbuf_q      <= rbuf_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      pins_q      <= pins_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign tms       = pins_q.tms;
  assign tdi       = pins_q.tdi;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Scoreboard bench for jtag_shift_engine: expected TDO bytes are queued at
// stimulus time and popped by an independent rd monitor.
module tb_jtag_shift_engine;
  import jtag_pkg::*;

  localparam int unsigned TCK_DIV = 2;
  localparam int unsigned LEN_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [LEN_W-1:0] cmd_nbits = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [7:0]       wr_data = 8'h00;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [7:0]       rd_data;
  logic             busy, tck, tms, tdi, tdo;
  logic             tdo_one = 1'b0;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic [7:0] exp_rd[$];
  int         rise_cyc[$];
  logic       rise_tms[$];

  assign tdo = tdo_one ? 1'b1 : tdi;

  jtag_shift_engine #(.TCK_DIV(TCK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_nbits(cmd_nbits),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT event", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: tck pulse log, high-phase width, rd scoreboard, rd hold stability.
  logic       tck_prev = 1'b0;
  int         hi_len = 0;
  logic       rd_hold = 1'b0;
  logic [7:0] rd_hold_data = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (tck && !tck_prev) begin
        rise_cyc.push_back(cyc);
        rise_tms.push_back(tms);
      end
      if (tck) hi_len++;
      else if (tck_prev) begin
        check("tck_high_len", 32'(hi_len), 32'(TCK_DIV));
        hi_len = 0;
      end
      if (wr_valid && wr_ready) wr_cnt++;
      if (rd_hold) check("rd_hold_stable", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, rd_hold_data});
      if (rd_valid && rd_ready) begin
        rd_cnt++;
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got 0x%0h, expected no byte", rd_data);
        end else begin
          check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
        end
      end
      rd_hold      = rd_valid && !rd_ready;
      rd_hold_data = rd_data;
    end else begin
      hi_len  = 0;
      rd_hold = 1'b0;
    end
    tck_prev = tck;
  end

  task automatic clear_log();
    rise_cyc.delete();
    rise_tms.delete();
  endtask

  function automatic logic [31:0] tms_vec();
    logic [31:0] v;
    v = '0;
    foreach (rise_tms[i]) if (i < 32) v[i] = rise_tms[i];
    return v;
  endfunction

  task automatic send_cmd(input jtag_op_e op, input int nbits, output int acc);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_nbits = LEN_W'(nbits);
    n = 0;
    while (!cmd_ready && n < 200) begin step(); n++; end
    if (n >= 200) fail_timeout("cmd_accept");
    acc = cyc + 1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] d);
    int n;
    wr_valid = 1'b1;
    wr_data  = d;
    n = 0;
    while (!wr_ready && n < 500) begin step(); n++; end
    if (n >= 500) fail_timeout("wr_accept");
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc);
    int n;
    n = 0;
    while ((busy || rd_valid || exp_rd.size() != 0) && n < 2000) begin step(); n++; end
    if (n >= 2000) fail_timeout("cmd_done");
    done_cyc = cyc;
  endtask

  task automatic run_reset(input string name);
    int acc, done, bad, w0, r0;
    clear_log();
    w0 = wr_cnt;
    r0 = rd_cnt;
    send_cmd(JTAG_OP_RESET, 0, acc);
    wait_done(done);
    check({name, "_rises"}, 32'(rise_cyc.size()), 32'd6);
    check({name, "_tms_pattern"}, tms_vec(), 32'h1F);
    check({name, "_busy_cycles"}, 32'(done - acc), 32'd25);
    if (rise_cyc.size() > 0) check({name, "_first_rise"}, 32'(rise_cyc[0] - acc), 32'd3);
    bad = 0;
    for (int i = 1; i < rise_cyc.size(); i++) if (rise_cyc[i] - rise_cyc[i-1] != 4) bad++;
    check({name, "_period_bad"}, 32'(bad), 32'd0);
    check({name, "_no_bytes"}, 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
    check({name, "_end_pins"}, {29'd0, tck, tms, tdi}, 32'd0);
  endtask

  initial begin
    int acc, done, bad, n, w0, r0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_pins", {29'd0, tck, tms, tdi}, 32'd0);
    check("reset_handshake", {29'd0, cmd_ready, wr_ready, rd_valid}, 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    repeat (3) step();
    check("reset_cmd_ready_low", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
    rd_ready = 1'b1;

    run_reset("reset1");

    // TMS_SEQ 5 bits of 0x1A: tms 0,1,0,1,1
    clear_log();
    w0 = wr_cnt;
    r0 = rd_cnt;
    send_cmd(JTAG_OP_TMS_SEQ, 5, acc);
    put_byte(8'h1A);
    wait_done(done);
    check("tms_seq_rises", 32'(rise_cyc.size()), 32'd5);
    check("tms_seq_pattern", tms_vec(), 32'h1A);
    check("tms_seq_wr_bytes", 32'(wr_cnt - w0), 32'd1);
    check("tms_seq_rd_bytes", 32'(rd_cnt - r0), 32'd0);
    check("tms_seq_end_tms", 32'(tms), 32'd0);

    // SCAN 12 bits, loopback
    clear_log();
    w0 = wr_cnt;
    r0 = rd_cnt;
    tdo_one = 1'b0;
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h03);
    send_cmd(JTAG_OP_SCAN, 12, acc);
    put_byte(8'hA5);
    put_byte(8'h03);
    wait_done(done);
    check("scan12_rises", 32'(rise_cyc.size()), 32'd12);
    check("scan12_tms_low", tms_vec(), 32'h0);
    check("scan12_rd_bytes", 32'(rd_cnt - r0), 32'd2);
    check("scan12_wr_bytes", 32'(wr_cnt - w0), 32'd2);

    // SCAN_FLIP_TMS 8 bits, tdo tied high
    clear_log();
    r0 = rd_cnt;
    tdo_one = 1'b1;
    exp_rd.push_back(8'hFF);
    send_cmd(JTAG_OP_SCAN_FLIP_TMS, 8, acc);
    put_byte(8'hFF);
    wait_done(done);
    check("flip_rises", 32'(rise_cyc.size()), 32'd8);
    check("flip_tms_pattern", tms_vec(), 32'h80);
    check("flip_end_tms", 32'(tms), 32'd0);
    check("flip_rd_bytes", 32'(rd_cnt - r0), 32'd1);
    tdo_one = 1'b0;

    // Zero-length SCAN: no activity
    clear_log();
    w0 = wr_cnt;
    r0 = rd_cnt;
    send_cmd(JTAG_OP_SCAN, 0, acc);
    check("zero_len_busy", 32'(busy), 32'd0);
    repeat (10) step();
    check("zero_len_idle", {30'd0, cmd_ready, busy}, 32'h2);
    check("zero_len_activity", 32'(rise_cyc.size() + (wr_cnt - w0) + (rd_cnt - r0)), 32'd0);

    // Backpressure: wr stall then rd stall, data must be unaffected
    clear_log();
    exp_rd.push_back(8'h3C);
    exp_rd.push_back(8'h96);
    rd_ready = 1'b0;
    send_cmd(JTAG_OP_SCAN, 16, acc);
    put_byte(8'h3C);
    n = 0;
    while (!wr_ready && n < 500) begin step(); n++; end
    if (n >= 500) fail_timeout("stall_wr_fetch");
    bad = 0;
    repeat (20) begin step(); if (tck !== 1'b0 || wr_ready !== 1'b1) bad++; end
    check("wr_stall_tck_low", 32'(bad), 32'd0);
    put_byte(8'h96);
    n = 0;
    while (rise_cyc.size() < 16 && n < 500) begin step(); n++; end
    if (n >= 500) fail_timeout("stall_rises");
    bad = 0;
    repeat (30) begin step(); if (tck !== 1'b0 || rd_valid !== 1'b1 || busy !== 1'b1) bad++; end
    check("rd_stall_tck_low", 32'(bad), 32'd0);
    rd_ready = 1'b1;
    wait_done(done);
    check("stall_rises", 32'(rise_cyc.size()), 32'd16);

    // Reset in the middle of the 3rd bit of a SCAN
    clear_log();
    send_cmd(JTAG_OP_SCAN, 8, acc);
    put_byte(8'h04);
    n = 0;
    while (rise_cyc.size() < 3 && n < 500) begin step(); n++; end
    if (n >= 500) fail_timeout("midreset_rises");
    #2;
    check("midreset_pre_tdi", 32'(tdi), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_pins", {29'd0, tck, tms, tdi}, 32'd0);
    check("midreset_outputs", {29'd0, rd_valid, busy, cmd_ready}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midreset_no_rd", 32'(rd_valid), 32'd0);

    run_reset("reset2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
